// File: rtl/inst_rom_timed_if.sv
// Bus between the IF stage and the timed instruction ROM.
//  master (IF stage): drives cs/addr; receives dout, rom_stall, range_err, stall_cycles
//  slave  (ROM):      receives cs/addr; drives dout, rom_stall, range_err, stall_cycles
//  cs           fetch request; addr must stay stable while rom_stall=1
//  addr         32-bit word address
//  dout         registered fetched word
//  rom_stall    high while the requested word is not yet valid
//  range_err    registered; last completed fetch was outside the ROM
//  stall_cycles saturating count of stalled cycles
interface inst_rom_timed_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 16
);
    logic                  cs;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rom_stall;
    logic                  range_err;
    logic [STAT_WIDTH-1:0] stall_cycles;

    modport master (
        output cs, addr,
        input  dout, rom_stall, range_err, stall_cycles
    );

    modport slave (
        input  cs, addr,
        output dout, rom_stall, range_err, stall_cycles
    );
endinterface

// File: rtl/inst_rom_timed.sv
// Instruction ROM with configurable access latency. Random accesses take
// LATENCY cycles; a fetch of (last completed address + 1) takes SEQ_LATENCY
// cycles, emulating a burst/prefetch memory. rom_stall holds the pipeline
// until dout is valid. Out-of-range fetches return 0 and flag range_err.
// Ports:
//  clk  rising-edge clock
//  rst  synchronous reset, active-high
//  bus  slave side of inst_rom_timed_if (cs, addr, dout, rom_stall,
//       range_err, stall_cycles)
// The store is filled with a fixed address-derived pattern.
module inst_rom_timed #(
    parameter int    ADDR_WIDTH  = 6,
    parameter int    DATA_WIDTH  = 32,
    parameter int    LATENCY     = 7,
    parameter int    SEQ_LATENCY = 2,
    parameter int    STAT_WIDTH  = 16,
    parameter string INIT_FILE   = "inst_mem.hex"
) (
    input logic             clk,
    input logic             rst,
    inst_rom_timed_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         lat;
    logic [31:0]           req_addr;
    logic [31:0]           last_addr;
    logic [31:0]           fetch_addr;
    logic                  last_valid;
    logic                  ack;
    logic                  start_access;
    logic                  complete;
    logic [DATA_WIDTH-1:0] dout;
    logic                  range_err;
    logic [STAT_WIDTH-1:0] stall_cycles;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic [DATA_WIDTH-1:0] pattern_word(input int idx);
        return DATA_WIDTH'(32'h1000_0000 + 32'(idx) * 32'h0003_0007);
    endfunction

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_word
            assign mem[i] = pattern_word(i);
        end
    endgenerate

    // start_access: a new request begins this cycle (from IDLE, or the address
    // moved away from the one in flight / already served). complete: the word
    // is loaded at this edge, either a 1-cycle access or the end of a WAIT.
    always_comb begin
        ack          = !rst && (state == ST_DONE) && (bus.addr == req_addr);
        lat          = (last_valid && (bus.addr == last_addr + 32'd1)) ?
                       CW'(SEQ_LATENCY) : CW'(LATENCY);
        start_access = bus.cs && ((state == ST_IDLE) || (bus.addr != req_addr));
        complete     = start_access ? (lat == CW'(1)) :
                       (bus.cs && (state == ST_WAIT) && (cnt == CW'(1)));
        fetch_addr   = start_access ? bus.addr : req_addr;
    end

    assign bus.rom_stall    = bus.cs & ~ack;
    assign bus.dout         = dout;
    assign bus.range_err    = range_err;
    assign bus.stall_cycles = stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_addr     <= '0;
            last_addr    <= '0;
            last_valid   <= 1'b0;
            dout         <= '0;
            range_err    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (bus.rom_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STAT_WIDTH'(1);
            end

            // Dropping cs abandons any access; dout and history are kept.
            if (!bus.cs) begin
                state <= ST_IDLE;
            end else if (complete) begin
                state      <= ST_DONE;
                req_addr   <= fetch_addr;
                last_addr  <= fetch_addr;
                last_valid <= 1'b1;
                if (fetch_addr[31:ADDR_WIDTH] != '0) begin
                    dout      <= '0;
                    range_err <= 1'b1;
                end else begin
                    dout      <= mem[fetch_addr[ADDR_WIDTH-1:0]];
                    range_err <= 1'b0;
                end
            end else if (start_access) begin
                req_addr <= bus.addr;
                cnt      <= lat - CW'(1);
                state    <= ST_WAIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_inst_rom_timed.sv
// Self-checking bench for inst_rom_timed. Two instances share the same
// cs/addr stimulus: one with a 16-bit stall counter and one with a 4-bit
// counter to exercise saturation. A cost-per-request reference model predicts
// every output each cycle; directed table vectors and hand sequences pin down
// the latency and range corner cases, then randomized traffic follows.
module tb_inst_rom_timed;
    localparam int LAT = 7;
    localparam int SEQ = 2;

    logic clk;
    logic rst;

    inst_rom_timed_if #(.DATA_WIDTH(32), .STAT_WIDTH(16)) bus_a ();
    inst_rom_timed_if #(.DATA_WIDTH(32), .STAT_WIDTH(4))  bus_b ();

    assign bus_b.cs   = bus_a.cs;
    assign bus_b.addr = bus_a.addr;

    inst_rom_timed #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(LAT), .SEQ_LATENCY(SEQ),
        .STAT_WIDTH(16), .INIT_FILE("")
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    inst_rom_timed #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(LAT), .SEQ_LATENCY(SEQ),
        .STAT_WIDTH(4), .INIT_FILE("")
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: an active request carries a remaining stall budget.
    bit          m_active;
    logic [31:0] m_req;
    int          m_left;
    logic [31:0] m_last;
    bit          m_last_valid;
    logic [31:0] m_dout;
    bit          m_rerr;
    int          m_stat;

    typedef struct {
        bit          rst;
        bit          cs;
        logic [31:0] addr;
        bit          exp_stall;
        bit          chk;
        logic [31:0] exp_dout;
        bit          exp_rerr;
        int          exp_stat;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {26'd0, a[5:0]} * 32'h0003_0007;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input logic [31:0] a, output bit stall);
        if (r) begin
            stall        = c;
            m_active     = 0;
            m_last_valid = 0;
            m_dout       = '0;
            m_rerr       = 0;
            m_stat       = 0;
            return;
        end
        if (!c) begin
            stall    = 0;
            m_active = 0;
            return;
        end
        if (!m_active || a != m_req) begin
            m_active = 1;
            m_req    = a;
            m_left   = (m_last_valid && a == m_last + 32'd1) ? SEQ : LAT;
        end
        stall = (m_left != 0);
        if (stall) begin
            m_stat++;
            m_left--;
            if (m_left == 0) begin
                m_last       = m_req;
                m_last_valid = 1;
                m_rerr       = (m_req[31:6] != '0);
                m_dout       = m_rerr ? 32'd0 : rom_word(m_req);
            end
        end
    endtask

    task automatic check_output();
        bit exp_stall;
        check("dout",       bus_a.dout,         m_dout);
        check("dout_b",     bus_b.dout,         m_dout);
        check("range_err",  bus_a.range_err,    m_rerr);
        check("stat16",     bus_a.stall_cycles, sat(m_stat, 65535));
        check("stat4",      bus_b.stall_cycles, sat(m_stat, 15));
        model_step(rst, bus_a.cs, bus_a.addr, exp_stall);
        check("rom_stall",   bus_a.rom_stall, exp_stall);
        check("rom_stall_b", bus_b.rom_stall, exp_stall);
    endtask

    task automatic apply_stimulus(input bit r, input bit c, input logic [31:0] a);
        @(posedge clk);
        #1;
        rst        = r;
        bus_a.cs   = c;
        bus_a.addr = a;
        #3;
        check_output();
    endtask

    task automatic add_vec(input logic [31:0] a, input bit st, input bit chk,
                           input logic [31:0] d, input int s);
        vec_t v;
        v.rst = 0; v.cs = 1; v.addr = a; v.exp_stall = st; v.chk = chk;
        v.exp_dout = d; v.exp_rerr = 0; v.exp_stat = s;
        vecs.push_back(v);
    endtask

    // Holds cs/addr until rom_stall drops; n is the number of stalled cycles.
    task automatic run_fetch(input logic [31:0] a, input string name, output int n);
        bit ended;
        n     = 0;
        ended = 0;
        for (int i = 0; i < 30 && !ended; i++) begin
            apply_stimulus(0, 1, a);
            if (bus_a.rom_stall) n++;
            else ended = 1;
        end
        if (!ended) check({name, "_timeout"}, 1, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] a;
        int r;

        rst = 1; bus_a.cs = 0; bus_a.addr = '0;
        m_active = 0; m_req = '0; m_left = 0; m_last = '0; m_last_valid = 0;
        m_dout = '0; m_rerr = 0; m_stat = 0;

        // Random access to 5, then sequential 6, then random 9.
        for (int k = 0; k < 8; k++) add_vec(32'h5, k < 7, k == 7, rom_word(32'h5), 7);
        for (int k = 0; k < 3; k++) add_vec(32'h6, k < 2, k == 2, rom_word(32'h6), 9);
        for (int k = 0; k < 8; k++) add_vec(32'h9, k < 7, k == 7, rom_word(32'h9), 16);

        apply_stimulus(1, 0, 0);
        check("reset_stall_cs0", bus_a.rom_stall, 0);
        apply_stimulus(1, 1, 0);
        check("reset_stall_cs1", bus_a.rom_stall, 1);
        apply_stimulus(1, 0, 0);
        check("reset_dout", bus_a.dout, 0);
        check("reset_stat", bus_a.stall_cycles, 0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].cs, vecs[i].addr);
            check("tbl_stall", bus_a.rom_stall, vecs[i].exp_stall);
            if (vecs[i].chk) begin
                check("tbl_dout", bus_a.dout, vecs[i].exp_dout);
                check("tbl_rerr", bus_a.range_err, vecs[i].exp_rerr);
                check("tbl_stat", bus_a.stall_cycles, vecs[i].exp_stat);
            end
        end

        // Address change mid-WAIT restarts the full latency.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, 1, 32'h3);
            check("restart_pre_stall", bus_a.rom_stall, 1);
        end
        run_fetch(32'h8, "restart", n);
        check("restart_len", n, LAT);
        check("restart_dout", bus_a.dout, rom_word(32'h8));

        // Out-of-range fetch, then an in-range one clears the flag.
        run_fetch(32'h40, "oor", n);
        check("oor_len", n, LAT);
        check("oor_dout", bus_a.dout, 0);
        check("oor_rerr", bus_a.range_err, 1);
        run_fetch(32'h2, "after_oor", n);
        check("after_oor_len", n, LAT);
        check("after_oor_rerr", bus_a.range_err, 0);
        check("after_oor_dout", bus_a.dout, rom_word(32'h2));

        // Abort in WAIT then retry the same address.
        for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 32'h10);
        apply_stimulus(0, 0, 32'h10);
        check("abort_stall", bus_a.rom_stall, 0);
        check("abort_dout", bus_a.dout, rom_word(32'h2));
        run_fetch(32'h10, "retry", n);
        check("retry_len", n, LAT);
        check("retry_dout", bus_a.dout, rom_word(32'h10));

        // Saturation of the 4-bit counter, then reset mid-WAIT.
        apply_stimulus(1, 0, 0);
        run_fetch(32'h20, "sat1", n);
        run_fetch(32'h30, "sat2", n);
        run_fetch(32'h11, "sat3", n);
        check("sat_stat4", bus_b.stall_cycles, 15);
        check("sat_stat16", bus_a.stall_cycles, 21);
        apply_stimulus(0, 1, 32'h11);
        apply_stimulus(0, 1, 32'h11);
        check("sat_hold", bus_b.stall_cycles, 15);
        for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 32'h12);
        apply_stimulus(1, 1, 32'h12);
        check("rst_mid_stall", bus_a.rom_stall, 1);
        run_fetch(32'h12, "after_rst", n);
        check("after_rst_len", n, LAT);
        check("after_rst_stat4", bus_b.stall_cycles, 7);
        check("after_rst_stat16", bus_a.stall_cycles, 7);

        // Randomized traffic against the model.
        a = 32'h0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      a = a;
            else if (r < 70) a = a + 32'd1;
            else if (r < 93) a = 32'($urandom_range(0, 63));
            else if (r < 98) a = 32'($urandom_range(0, 127));
            else             a = 32'hFFFF_FFFF;
            apply_stimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
